// File: rtl/lstm_bptt_ctrl_pkg.sv
// Shared definitions for the LSTM backprop blocks: FSM state encoding and fixed-point defaults.
package lstm_bptt_ctrl_pkg;

  localparam int          DEF_WIDTH = 32;
  localparam int          DEF_FRAC  = 24;
  localparam logic [31:0] FX_ONE    = 32'h01000000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_CAPT = 3'd3,
    S_DONE = 3'd4
  } bptt_state_e;

endpackage

// File: rtl/lstm_bptt_ctrl_step_cnt.sv
// Timestep down-counter: load with LEN-1, decrement once per step, flags the first and last step.
module bptt_step_cnt #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [AW-1:0] i_load_val,
  input  logic          i_dec,
  input  logic          i_clr,
  output logic [AW-1:0] o_cnt,
  output logic          o_zero,
  output logic          o_first,
  output logic          o_last
);

  logic [AW-1:0] r_cnt;
  logic          r_first;
  logic          r_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= i_load_val;
      r_first <= 1'b1;
      r_last  <= (i_load_val == '0);
    end else if (i_clr) begin
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else if (i_dec) begin
      r_cnt   <= r_cnt - AW'(1);
      r_first <= 1'b0;
      // The step we are entering is t==0 when we leave t==1.
      r_last  <= (r_cnt == AW'(1));
    end
  end

  assign o_cnt   = r_cnt;
  assign o_zero  = (r_cnt == '0);
  assign o_first = r_first;
  assign o_last  = r_last;

endmodule

// File: rtl/lstm_bptt_ctrl.sv
// BPTT sequencer: walks t=LEN-1..0 as READ/WAIT/CAPT steps, strobes RAM reads and gradient
// writes, and registers the datapath's d_h/d_c outputs as next-step feedback.
module lstm_bptt_ctrl
  import lstm_bptt_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NUM_LSTM = 1,
  parameter int TSTEP    = 16,
  parameter int AW       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic [AW:0]               i_len,
  input  logic [NUM_LSTM*WIDTH-1:0] i_d_h_next,
  input  logic [WIDTH-1:0]          i_d_c_next,
  output logic                      o_rd_en,
  output logic [AW-1:0]             o_rd_addr,
  output logic [NUM_LSTM*WIDTH-1:0] o_d_h_prev,
  output logic [WIDTH-1:0]          o_d_c_prev,
  output logic                      o_first,
  output logic                      o_last,
  output logic                      o_wr_en,
  output logic [AW-1:0]             o_wr_addr,
  output logic                      o_busy,
  output logic                      o_done
);

  bptt_state_e r_state;

  logic                      r_rd_en;
  logic [AW-1:0]             r_rd_addr;
  logic                      r_wr_en;
  logic [AW-1:0]             r_wr_addr;
  logic                      r_busy;
  logic                      r_done;
  logic [NUM_LSTM*WIDTH-1:0] r_d_h_prev;
  logic [WIDTH-1:0]          r_d_c_prev;

  logic [AW:0]   w_len_c;
  logic [AW-1:0] w_load_val;
  logic          w_load;
  logic          w_dec;
  logic          w_clr;
  logic [AW-1:0] w_t;
  logic          w_zero;
  logic          w_first;
  logic          w_last;

  // Oversized lengths run the full supported depth rather than wrapping the address.
  assign w_len_c    = (i_len > (AW+1)'(TSTEP)) ? (AW+1)'(TSTEP) : i_len;
  assign w_load_val = AW'(w_len_c - (AW+1)'(1));

  assign w_load = (r_state == S_IDLE) && i_start && (w_len_c != '0);
  assign w_dec  = (r_state == S_CAPT) && !w_zero;
  assign w_clr  = (r_state == S_CAPT) && w_zero;

  bptt_step_cnt #(.AW(AW)) u_step_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .i_clr      (w_clr),
    .o_cnt      (w_t),
    .o_zero     (w_zero),
    .o_first    (w_first),
    .o_last     (w_last)
  );

  // Strobes are set on the transition into their state so every output comes from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_d_h_prev <= '0;
      r_d_c_prev <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (w_len_c == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= S_READ;
              r_rd_en    <= 1'b1;
              r_rd_addr  <= w_load_val;
              r_d_h_prev <= '0;
              r_d_c_prev <= '0;
            end
          end
        end
        S_READ: begin
          r_state <= S_WAIT;
          r_rd_en <= 1'b0;
        end
        S_WAIT: begin
          r_state   <= S_CAPT;
          r_wr_en   <= 1'b1;
          r_wr_addr <= w_t;
        end
        S_CAPT: begin
          r_wr_en    <= 1'b0;
          r_d_h_prev <= i_d_h_next;
          r_d_c_prev <= i_d_c_next;
          if (w_zero) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state   <= S_READ;
            r_rd_en   <= 1'b1;
            r_rd_addr <= w_t - AW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_rd_en <= 1'b0;
          r_wr_en <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_en    = r_rd_en;
  assign o_rd_addr  = r_rd_addr;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_first    = w_first;
  assign o_last     = w_last;
  assign o_d_h_prev = r_d_h_prev;
  assign o_d_c_prev = r_d_c_prev;

endmodule

// File: tb/tb_lstm_bptt_ctrl.sv
// Self-checking bench: directed table of runs plus randomized runs, every cycle compared
// against a schedule model computed from step/phase arithmetic.
module tb_lstm_bptt_ctrl;

  localparam int WIDTH    = 32;
  localparam int NUM_LSTM = 1;
  localparam int TSTEP    = 16;
  localparam int AW       = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      i_start;
  logic [AW:0]               i_len;
  logic [NUM_LSTM*WIDTH-1:0] i_d_h_next;
  logic [WIDTH-1:0]          i_d_c_next;
  logic                      o_rd_en;
  logic [AW-1:0]             o_rd_addr;
  logic [NUM_LSTM*WIDTH-1:0] o_d_h_prev;
  logic [WIDTH-1:0]          o_d_c_prev;
  logic                      o_first;
  logic                      o_last;
  logic                      o_wr_en;
  logic [AW-1:0]             o_wr_addr;
  logic                      o_busy;
  logic                      o_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] fb_h = '0;
  logic [31:0] fb_c = '0;

  always #5 clk = ~clk;

  lstm_bptt_ctrl #(.WIDTH(WIDTH), .NUM_LSTM(NUM_LSTM), .TSTEP(TSTEP), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_len      (i_len),
    .i_d_h_next (i_d_h_next),
    .i_d_c_next (i_d_c_next),
    .o_rd_en    (o_rd_en),
    .o_rd_addr  (o_rd_addr),
    .o_d_h_prev (o_d_h_prev),
    .o_d_c_prev (o_d_c_prev),
    .o_first    (o_first),
    .o_last     (o_last),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  typedef struct {
    int len;
    int restart;
    int rstc;
    bit fixed;
    int exp_wr;
    int exp_done;
  } vec_t;

  task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
    end
  endtask

  task automatic run(input int len, input int restart, input int rstc, input bit fixed,
                     input int exp_wr, input int exp_done);
    int L, ncyc, wr_cnt, done_at, k, ph, n;
    logic [31:0] dh_d [0:63];
    logic [31:0] dc_d [0:63];
    logic        e_rd, e_wr, e_first, e_last, e_busy, e_done;
    logic [31:0] e_h, e_c;
    int          e_t;
    bit          ab;
    L = (len > TSTEP) ? TSTEP : len;
    ncyc = 3*L + 3;
    wr_cnt = 0;
    done_at = -1;
    e_h = fb_h;
    e_c = fb_c;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      rst     = (c == rstc);
      i_start = (c == 0) || (c == restart);
      i_len   = (c == 0) ? (AW+1)'(len) : (AW+1)'($urandom_range(0, 31));
      dh_d[c] = fixed ? 32'hFF000000 : $urandom;
      dc_d[c] = fixed ? 32'h00800000 : $urandom;
      i_d_h_next = dh_d[c];
      i_d_c_next = dc_d[c];
      @(negedge clk);
      ab = (rstc >= 0) && (c > rstc);
      e_rd = 0; e_wr = 0; e_first = 0; e_last = 0; e_busy = 0; e_done = 0; e_t = 0;
      e_h = fb_h; e_c = fb_c;
      if (ab) begin
        e_h = '0; e_c = '0;
      end else if (c >= 1) begin
        if (L == 0) begin
          e_busy = (c == 1);
          e_done = (c == 1);
        end else begin
          if (c <= 3*L) begin
            k  = (c - 1) / 3;
            ph = (c - 1) % 3;
            e_t     = L - 1 - k;
            e_rd    = (ph == 0);
            e_wr    = (ph == 2);
            e_first = (k == 0);
            e_last  = (k == L - 1);
          end
          e_busy = (c <= 3*L + 1);
          e_done = (c == 3*L + 1);
          n = (c - 1) / 3;
          if (n > L) n = L;
          // Feedback after n completed steps is the data driven in the CAPT of step n-1.
          if (n == 0) begin e_h = '0; e_c = '0; end
          else begin e_h = dh_d[3*n]; e_c = dc_d[3*n]; end
        end
      end
      chk("rd_en", c, 64'(o_rd_en), 64'(e_rd));
      chk("wr_en", c, 64'(o_wr_en), 64'(e_wr));
      chk("first", c, 64'(o_first), 64'(e_first));
      chk("last",  c, 64'(o_last),  64'(e_last));
      chk("busy",  c, 64'(o_busy),  64'(e_busy));
      chk("done",  c, 64'(o_done),  64'(e_done));
      chk("d_h_prev", c, 64'(o_d_h_prev), 64'(e_h));
      chk("d_c_prev", c, 64'(o_d_c_prev), 64'(e_c));
      if (e_rd) chk("rd_addr", c, 64'(o_rd_addr), 64'(e_t));
      if (e_wr) chk("wr_addr", c, 64'(o_wr_addr), 64'(e_t));
      if (o_wr_en) wr_cnt++;
      if (o_done && done_at < 0) done_at = c;
    end
    @(posedge clk); #1;
    rst = 0;
    i_start = 0;
    fb_h = e_h;
    fb_c = e_c;
    chk("wr_count", len, 64'(wr_cnt), 64'(exp_wr));
    chk("done_cycle", len, 64'(done_at), 64'(exp_done));
  endtask

  vec_t vecs [9];

  initial begin
    vecs[0] = '{len:4,  restart:-1, rstc:-1, fixed:0, exp_wr:4,  exp_done:13};
    vecs[1] = '{len:4,  restart:-1, rstc:-1, fixed:1, exp_wr:4,  exp_done:13};
    vecs[2] = '{len:1,  restart:-1, rstc:-1, fixed:0, exp_wr:1,  exp_done:4};
    vecs[3] = '{len:0,  restart:-1, rstc:-1, fixed:0, exp_wr:0,  exp_done:1};
    vecs[4] = '{len:4,  restart:5,  rstc:-1, fixed:0, exp_wr:4,  exp_done:13};
    vecs[5] = '{len:19, restart:-1, rstc:-1, fixed:0, exp_wr:16, exp_done:49};
    vecs[6] = '{len:4,  restart:-1, rstc:7,  fixed:0, exp_wr:2,  exp_done:-1};
    vecs[7] = '{len:4,  restart:-1, rstc:-1, fixed:1, exp_wr:4,  exp_done:13};
    vecs[8] = '{len:16, restart:-1, rstc:-1, fixed:0, exp_wr:16, exp_done:49};

    rst = 1; i_start = 0; i_len = '0; i_d_h_next = '0; i_d_c_next = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", 0,
        64'({o_rd_en, o_wr_en, o_first, o_last, o_busy, o_done, o_rd_addr, o_wr_addr}), 64'(0));
    chk("reset_fb", 0, 64'({o_d_h_prev, o_d_c_prev}), 64'(0));
    @(posedge clk); #1;
    rst = 0;

    for (int v = 0; v < 9; v++)
      run(vecs[v].len, vecs[v].restart, vecs[v].rstc, vecs[v].fixed, vecs[v].exp_wr, vecs[v].exp_done);

    for (int r = 0; r < 25; r++) begin
      int len, L, rs;
      len = $urandom_range(0, 31);
      L = (len > TSTEP) ? TSTEP : len;
      rs = (L == 0) ? -1 : $urandom_range(1, 3*L + 1);
      run(len, rs, -1, 1'b0, L, 3*L + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
